// File: rtl/mem_store_buffer.sv
// mem_store_buffer
//   Store buffer sitting in front of data_mem in the MEM stage. Stores are
//   queued in a small FIFO and drained one per cycle whenever no load needs the
//   shared memory port. Loads always get the port first. A load whose word set
//   overlaps a queued store stalls until that store has drained.
//
//   Optional feature macro: STB_FWD_EN
//     When defined, a load whose youngest overlapping store has the same address
//     and is at least as wide is served directly from the buffer. It does not
//     stall and it does not use the memory port.
//     When undefined, every overlapping load stalls and no forwarding logic is
//     built.
module mem_store_buffer #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst_n_i,
    input  logic              st_valid_i,
    input  logic [ADDR_W-1:0] st_addr_i,
    input  logic [31:0]       st_data_i,
    input  logic [1:0]        st_type_i,
    output logic              st_ready_o,
    input  logic              ld_valid_i,
    input  logic [ADDR_W-1:0] ld_addr_i,
    input  logic [2:0]        ld_type_i,
    output logic              ld_stall_o,
    output logic [31:0]       ld_data_o,
    output logic              mem_rd_en_o,
    output logic              mem_wr_en_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [31:0]       mem_wr_data_o,
    output logic [1:0]        mem_store_type_o,
    output logic [2:0]        mem_load_type_o,
    input  logic [31:0]       mem_rd_data_i,
    output logic              empty_o
);

    localparam int PTR_W  = $clog2(DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int WORD_W = ADDR_W - 2;

    // Offset from the first to the last byte touched by a store (size - 1).
    // Type 11 is treated as a word store.
    function automatic logic [ADDR_W-1:0] st_span(input logic [1:0] t);
        case (t)
            2'b00:   st_span = ADDR_W'(0);
            2'b01:   st_span = ADDR_W'(1);
            default: st_span = ADDR_W'(3);
        endcase
    endfunction

    // Offset from the first to the last byte touched by a load (size - 1).
    // Unlisted load types behave as a word load.
    function automatic logic [ADDR_W-1:0] ld_span(input logic [2:0] t);
        case (t)
            3'b000, 3'b001: ld_span = ADDR_W'(0);
            3'b010, 3'b011: ld_span = ADDR_W'(1);
            default:        ld_span = ADDR_W'(3);
        endcase
    endfunction

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]  count_q,  count_d;

    logic [ADDR_W-1:0] ent_addr_q [DEPTH];
    logic [31:0]       ent_data_q [DEPTH];
    logic [1:0]        ent_type_q [DEPTH];

    logic              push;
    logic              drain;
    logic              load_go;
    logic              fwd_hit;
    logic              any_overlap;

    logic [ADDR_W-1:0] ld_last;
    logic [WORD_W-1:0] ld_lo;
    logic [WORD_W-1:0] ld_hi;

    logic [DEPTH-1:0]  slot_valid;
    logic [DEPTH-1:0]  slot_overlap;

    // ------------------------------------------------------------------
    // Load word set. The last-byte address wraps modulo 2^ADDR_W.
    // ------------------------------------------------------------------
    assign ld_last = ld_addr_i + ld_span(ld_type_i);
    assign ld_lo   = ld_addr_i[ADDR_W-1:2];
    assign ld_hi   = ld_last[ADDR_W-1:2];

    // ------------------------------------------------------------------
    // Per-slot validity and conservative word-granular overlap check
    // ------------------------------------------------------------------
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
        logic [PTR_W-1:0]  age;
        logic [ADDR_W-1:0] st_last;
        logic [WORD_W-1:0] st_lo;
        logic [WORD_W-1:0] st_hi;

        // The age of a slot is its distance from the oldest entry. A slot is
        // live when its age is below the occupancy count.
        assign age             = PTR_W'(gi) - rd_ptr_q;
        assign slot_valid[gi]  = ({1'b0, age} < count_q);
        assign st_last         = ent_addr_q[gi] + st_span(ent_type_q[gi]);
        assign st_lo           = ent_addr_q[gi][ADDR_W-1:2];
        assign st_hi           = st_last[ADDR_W-1:2];
        // Each word set has at most two words, so checking all four pairs
        // covers every possible intersection.
        assign slot_overlap[gi] = slot_valid[gi] &&
                                  ((st_lo == ld_lo) || (st_lo == ld_hi) ||
                                   (st_hi == ld_lo) || (st_hi == ld_hi));
    end

    assign any_overlap = |slot_overlap;

`ifdef STB_FWD_EN
    // ------------------------------------------------------------------
    // Store-to-load forwarding from the youngest overlapping entry
    // ------------------------------------------------------------------
    logic              yng_found;
    logic [PTR_W-1:0]  yng_slot;
    logic [PTR_W-1:0]  scan_slot;
    logic [31:0]       yng_data;
    logic [31:0]       fwd_data;

    // Walk the entries from oldest to youngest. The last overlapping entry seen
    // is the youngest one.
    always_comb begin
        yng_found = 1'b0;
        yng_slot  = '0;
        scan_slot = '0;
        for (int k = 0; k < DEPTH; k++) begin
            scan_slot = rd_ptr_q + PTR_W'(k);
            if (slot_overlap[scan_slot]) begin
                yng_found = 1'b1;
                yng_slot  = scan_slot;
            end
        end
    end

    assign yng_data = ent_data_q[yng_slot];

    // Forward only when the youngest overlapping entry starts at the same byte
    // and covers at least the load width. Otherwise the load falls back to
    // stalling.
    assign fwd_hit = ld_valid_i && yng_found &&
                     (ent_addr_q[yng_slot] == ld_addr_i) &&
                     (st_span(ent_type_q[yng_slot]) >= ld_span(ld_type_i));

    // Truncate the forwarded data to the load width, then sign- or
    // zero-extend it.
    always_comb begin
        fwd_data = yng_data;
        case (ld_type_i)
            3'b000:  fwd_data = {{24{yng_data[7]}}, yng_data[7:0]};
            3'b001:  fwd_data = {24'h0, yng_data[7:0]};
            3'b010:  fwd_data = {{16{yng_data[15]}}, yng_data[15:0]};
            3'b011:  fwd_data = {16'h0, yng_data[15:0]};
            default: fwd_data = yng_data;
        endcase
    end

    assign ld_data_o = fwd_hit ? fwd_data : mem_rd_data_i;
`else
    assign fwd_hit   = 1'b0;
    assign ld_data_o = mem_rd_data_i;
`endif

    // ------------------------------------------------------------------
    // Port arbitration: a load that can proceed owns the port. Otherwise
    // the oldest queued store drains.
    // ------------------------------------------------------------------
    assign ld_stall_o = ld_valid_i && any_overlap && !fwd_hit;
    assign load_go    = ld_valid_i && !ld_stall_o && !fwd_hit;
    assign drain      = (count_q != '0) && !load_go;
    // Acceptance looks at registered occupancy only. A full buffer refuses a
    // push even while it is popping.
    assign st_ready_o = (count_q < CNT_W'(DEPTH));
    assign push       = st_valid_i && st_ready_o;
    assign empty_o    = (count_q == '0);

    // Drive the shared data_mem port from either the load or the head entry.
    always_comb begin
        mem_rd_en_o      = 1'b0;
        mem_wr_en_o      = 1'b0;
        mem_addr_o       = ent_addr_q[rd_ptr_q];
        mem_wr_data_o    = ent_data_q[rd_ptr_q];
        mem_store_type_o = ent_type_q[rd_ptr_q];
        mem_load_type_o  = ld_type_i;
        if (load_go) begin
            mem_rd_en_o = 1'b1;
            mem_addr_o  = ld_addr_i;
        end else if (drain) begin
            mem_wr_en_o = 1'b1;
        end
    end

    // Next-state for the pointers and occupancy. Both pointers wrap naturally
    // because DEPTH is a power of two.
    always_comb begin
        rd_ptr_d = rd_ptr_q + PTR_W'(drain);
        wr_ptr_d = wr_ptr_q + PTR_W'(push);
        count_d  = count_q + CNT_W'(push) - CNT_W'(drain);
    end

    // FIFO control registers. Reset discards every queued store.
    always_ff @(posedge clk or negedge rst_n_i) begin
        if (!rst_n_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Capture an accepted store in the slot at the write pointer. Entry
    // contents need no reset because validity comes from the pointers.
    always_ff @(posedge clk) begin
        if (push) begin
            ent_addr_q[wr_ptr_q] <= st_addr_i;
            ent_data_q[wr_ptr_q] <= st_data_i;
            ent_type_q[wr_ptr_q] <= st_type_i;
        end
    end

endmodule
